// File: rtl/divider_5bit_seq_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default width and the all-ones quotient constant.
package divider_5bit_seq_pkg;

  localparam int DIV_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    DIVZ = 2'd3
  } div_state_e;

  // Wide enough for any practical WIDTH; the top slices what it needs.
  localparam logic [31:0] DIV_QALL1 = '1;

endpackage

// File: rtl/divider_5bit_seq_sub.sv
// Ripple-carry subtractor X - Y built from full-adder cells as X + ~Y + 1.
// Carry-out high means no borrow (X >= Y).
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module subtractor_nbit #(
  parameter int N = 6
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  output logic [N-1:0] diff_o,
  output logic         cout_o
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a_i (x_i[i]),
      .b_i (~y_i[i]),
      .c_i (carry[i]),
      .s_o (diff_o[i]),
      .c_o (carry[i+1])
    );
  end

  assign cout_o = carry[N];

endmodule

// File: rtl/divider_5bit_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional divide-by-zero trap: define DIVIDER_DBZ_TRAP_EN.
module divider_5bit_seq
  import divider_5bit_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dbz
);

  localparam logic [WIDTH-1:0] QALL1    = DIV_QALL1[WIDTH-1:0];
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] bq_q, bq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   ps;
  logic [WIDTH:0]   t;
  logic             no_borrow;
  logic [WIDTH:0]   p_iter;
  logic [WIDTH-1:0] d_iter;
  logic             zero_div;
  logic             p_msb_unused;

  // The top bit of P only exists to hold the WIDTH+1-bit trial difference.
  assign p_msb_unused = p_q[WIDTH];

  assign ps = {p_q[WIDTH-1:0], d_q[WIDTH-1]};

  subtractor_nbit #(.N(WIDTH + 1)) u_sub (
    .x_i    (ps),
    .y_i    ({1'b0, bq_q}),
    .diff_o (t),
    .cout_o (no_borrow)
  );

  assign p_iter = no_borrow ? t : ps;
  assign d_iter = {d_q[WIDTH-2:0], no_borrow};

`ifdef DIVIDER_DBZ_TRAP_EN
  assign zero_div = (B == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = zero_div ? DIVZ : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DIVZ:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p_d   = p_q;
    d_d   = d_q;
    bq_d  = bq_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    r_d   = r_q;
    dbz_d = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          p_d   = '0;
          d_d   = A;
          bq_d  = B;
          cnt_d = CNT_LAST;
          q_d   = '0;
          r_d   = '0;
          dbz_d = 1'b0;
        end
      end
      CALC: begin
        p_d   = p_iter;
        d_d   = d_iter;
        cnt_d = cnt_q - 1'b1;
        // Publish the result on the final iteration so it is valid with done.
        if (cnt_q == '0) begin
          q_d = d_iter;
          r_d = p_iter[WIDTH-1:0];
        end
      end
      DIVZ: begin
        q_d   = QALL1;
        r_d   = d_q;
        dbz_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      d_q   <= '0;
      bq_q  <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      d_q   <= d_d;
      bq_q  <= bq_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dbz_q <= dbz_d;
    end
  end

  assign busy = (state_q == CALC) || (state_q == DIVZ);
  assign done = (state_q == DONE);
  assign Q    = q_q;
  assign R    = r_q;

`ifdef DIVIDER_DBZ_TRAP_EN
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

endmodule

// File: tb/tb_divider_5bit_seq.sv
// Scoreboard bench for divider_5bit_seq; honours DIVIDER_DBZ_TRAP_EN when defined.
module tb_divider_5bit_seq;

`ifdef DIVIDER_DBZ_TRAP_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] A = '0;
  logic [4:0] B = '0;
  logic       busy;
  logic       done;
  logic [4:0] Q;
  logic [4:0] R;
  logic       dbz;

  divider_5bit_seq #(.WIDTH(5), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int dbz;
    int lat;
    int start_edge;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   edge_cnt = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("Q", int'(Q), e.q);
        check("R", int'(R), e.r);
        check("dbz", int'(dbz), e.dbz);
        check("latency", edge_cnt - e.start_edge + 1, e.lat);
      end
    end
  end

  // Called at a negedge: drives start for one cycle and queues the expected result.
  task automatic issue(input int a, input int b, input bit push);
    exp_t e;
    A     = 5'(a);
    B     = 5'(b);
    start = 1'b1;
    if (push) begin
      if (b == 0) begin
        e.q = 31;
        e.r = a;
        e.dbz = DBZ_EN ? 1 : 0;
        e.lat = DBZ_EN ? 2 : 6;
      end else begin
        e.q = a / b;
        e.r = a % b;
        e.dbz = 0;
        e.lat = 6;
      end
      e.start_edge = edge_cnt + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    int d0;

    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_Q", int'(Q), 0);
    check("rst_R", int'(R), 0);
    check("rst_dbz", int'(dbz), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(20, 3, 1'b1);
    check("busy_calc", int'(busy), 1);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_done", int'(done), 0);
    check("hold_Q", int'(Q), 6);
    check("hold_R", int'(R), 2);

    issue(31, 1, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);
    issue(5, 7, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);

    // Starts during CALC with different operands must be ignored.
    d0 = done_cnt;
    issue(20, 3, 1'b1);
    A = 5'd31;
    B = 5'd31;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check("single_done", done_cnt - d0, 1);

    issue(18, 0, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of CALC aborts the division.
    issue(20, 3, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_Q", int'(Q), 0);
    check("abort_R", int'(R), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    issue(31, 5, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);

    // Zero dividend, then a back-to-back start in the cycle after done.
    issue(0, 5, 1'b1);
    wait_done();
    @(negedge clk);
    issue(20, 3, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider_5bit_seq.md
Name: divider_5bit_seq

Overview:
- Sequential unsigned divider; the inverse operation of the team's 5-bit ripple adder.
- Computes quotient and remainder of A / B using restoring division, one quotient bit per clock.
- Start/done handshake so a control FSM or testbench can launch a division and wait for the result.
- Subtraction is done by a ripple subtractor sub-module: adder with B inverted and carry-in = 1.

Parameters:
- WIDTH, 5, operand/quotient/remainder width. Spec and tests are written for 5.
- CNT_W, 3, iteration counter width. Must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch request; sampled only in IDLE
- A  in  WIDTH  dividend; captured on the accepted start edge
- B  in  WIDTH  divisor; captured on the accepted start edge
- busy  out  1  high while in CALC, or in DIVZ when the optional feature is compiled in
- done  out  1  one-cycle pulse: Q/R valid
- Q  out  WIDTH  quotient; held until next accepted start
- R  out  WIDTH  remainder; held until next accepted start
- dbz  out  1  divide-by-zero flag; valid with done

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, Q=0, R=0, dbz=0; internal registers P, D, Bq, cnt cleared. Reset during CALC aborts the division; no done is produced.
- Registered state: P (partial remainder, WIDTH+1 bits), D (dividend shift register), Bq (captured divisor), cnt.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge: D<=A, Bq<=B, P<=0, cnt<=WIDTH-1, Q and R cleared, busy<=1, next state CALC.
  - start=0: stay in IDLE.
- CALC, one iteration per edge:
  - Ps = {P[WIDTH-1:0], D[WIDTH-1]}.
  - T = Ps - {1'b0, Bq}, computed in WIDTH+1 bits by the sub-module.
  - No borrow (sub carry-out = 1): P<=T, quotient bit=1.
  - Borrow: P<=Ps, quotient bit=0.
  - D shifts left, inserting the quotient bit at the LSB, so D accumulates Q.
  - cnt decrements. On the edge where cnt==0: next state DONE, busy<=0.
- DONE (exactly one cycle): done=1, Q=D, R=P[WIDTH-1:0], then unconditionally to IDLE. start in this cycle is ignored.
- Latency: accepted start edge k. CALC edges are k+1..k+WIDTH. done is high in the cycle after edge k+WIDTH (k+5 for WIDTH=5), i.e. WIDTH+1 cycles after start.
- start while busy or done: ignored; operands are not re-captured.
- After done falls, Q/R/dbz hold their values until the next accepted start.
- A=0: Q=0, R=0.
- A<B: Q=0, R=A.
- B=0 without the feature: the algorithm naturally yields Q=all ones, R=A; dbz stays 0.
- All arithmetic is unsigned. There is no overflow: P is always < 2*Bq.

Optional Feature:
- Macro: DIVIDER_DBZ_TRAP_EN.
- Defined:
  - In IDLE, accepted start with B==0 goes to an extra state DIVZ for one cycle (busy=1), then DONE.
  - In DONE: done=1, dbz=1, Q=all ones, R=A.
  - Latency becomes 2 cycles instead of WIDTH+1.
- Undefined: no DIVZ state; dbz is tied to 0; B==0 runs the normal WIDTH-cycle path.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2, DIVZ=2'd3
  - default WIDTH
  - DIV_QALL1 constant (all-ones quotient)
- Sub-module: subtractor_nbit (parameter N=WIDTH+1).
  - Ripple chain of full adders computing X + ~Y + 1.
  - Outputs: difference, carry-out. carry-out=1 means no borrow.
  - Reuses the team's full-adder cell.

Test Plan:
- A=10100 (20), B=00011 (3), start for 1 cycle -> done exactly 6 cycles later, Q=00110, R=00010, dbz=0.
- A=11111, B=00001 -> Q=11111, R=00000. Then A=00101, B=00111 -> Q=00000, R=00101.
- Pulse start again at cycles 2 and 4 of a 20/3 run, with A=11111, B=11111 on the bus -> result is still Q=6, R=2, with only one done pulse.
- A=10010, B=00000:
  - Macro undefined -> Q=11111, R=10010, dbz=0, 6-cycle latency.
  - Macro defined -> same Q/R, dbz=1, 2-cycle latency.
- Start 20/3, drop rst_n at CALC cycle 3 asynchronously (mid-cycle) -> busy, done, Q, R immediately 0; no done follows. A new start of 31/5 after release -> Q=00110, R=00001.
- A=00000, B=00101 -> Q=0, R=0. Back-to-back start in the cycle after done -> accepted, with correct second result.
